// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with a start/done handshake.
// Single-cycle logic, arithmetic, compare and shift ops complete one cycle
// after acceptance. Unsigned multiply (shift-add) and divide (restoring)
// retire one bit per cycle over WIDTH cycles while busy is high.
// Results and flags are registered and change only on the done pulse.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [CW-1:0]    func,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             sign,
    output logic             ovf,
    output logic             carry,
    output logic             dz,
    output logic             err
);

    // Shift amount width; also sizes the iteration counter (0..WIDTH-1).
    localparam int SW = $clog2(WIDTH);

    localparam logic [CW-1:0] F_AND  = CW'(0);
    localparam logic [CW-1:0] F_OR   = CW'(1);
    localparam logic [CW-1:0] F_ADD  = CW'(2);
    localparam logic [CW-1:0] F_SUB  = CW'(3);
    localparam logic [CW-1:0] F_XOR  = CW'(4);
    localparam logic [CW-1:0] F_NOR  = CW'(5);
    localparam logic [CW-1:0] F_SLT  = CW'(6);
    localparam logic [CW-1:0] F_SLTU = CW'(7);
    localparam logic [CW-1:0] F_SLL  = CW'(8);
    localparam logic [CW-1:0] F_SRL  = CW'(9);
    localparam logic [CW-1:0] F_SRA  = CW'(10);
    localparam logic [CW-1:0] F_MULU = CW'(11);
    localparam logic [CW-1:0] F_DIVU = CW'(12);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Iterative datapath: hi_q is the partial product / partial remainder,
    // lo_q holds the multiplier / dividend bits that are shifted out while
    // product / quotient bits are shifted in, opb_q is the latched op2.
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opb_q;
    logic [SW-1:0]    cnt_q;

    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_trial;
    logic             div_ge;
    logic             last_iter;

    // Single-cycle arithmetic on the live inputs (used only on acceptance).
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [SW-1:0]    shamt;

    // Value to be registered on the done pulse.
    logic             load;
    logic             fin_valid;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH-1:0] fin_hi;
    logic             fin_zero;
    logic             fin_sign;
    logic             fin_ovf;
    logic             fin_carry;
    logic             fin_dz;
    logic             fin_err;

    assign busy      = (state != S_IDLE);
    assign last_iter = (cnt_q == SW'(WIDTH - 1));
    assign add_sum   = {1'b0, op1} + {1'b0, op2};
    // Bit WIDTH of the widened difference is the unsigned borrow (op1 < op2).
    assign sub_diff  = {1'b0, op1} - {1'b0, op2};
    assign shamt     = op2[SW-1:0];
    assign fin_zero  = (fin_res == '0);
    assign fin_sign  = fin_res[WIDTH-1];

    // One multiply or divide iteration from the current datapath registers.
    always_comb begin
        // NOTE: every signal written in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        step_hi   = hi_q;
        step_lo   = lo_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // Only used when div_shift >= opb_q, so the difference fits WIDTH bits.
        div_trial = div_shift[WIDTH-1:0] - opb_q;
        if (state == S_MUL) begin
            // Add the multiplicand when the low multiplier bit is set, then
            // shift the whole {hi, lo} pair right by one.
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (state == S_DIV) begin
            // Shift the next dividend bit into the remainder and subtract
            // the divisor only when it fits (restoring division).
            step_hi = div_ge ? div_trial : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    // Next-state logic and the result/flags to publish on the next done.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fin_valid = 1'b0;
        fin_res   = '0;
        fin_hi    = '0;
        fin_ovf   = 1'b0;
        fin_carry = 1'b0;
        fin_dz    = 1'b0;
        fin_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    fin_valid = 1'b1;
                    case (func)
                        F_AND:  fin_res = op1 & op2;
                        F_OR:   fin_res = op1 | op2;
                        F_XOR:  fin_res = op1 ^ op2;
                        F_NOR:  fin_res = ~(op1 | op2);
                        F_ADD: begin
                            fin_res   = add_sum[WIDTH-1:0];
                            fin_carry = add_sum[WIDTH];
                            fin_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                                        (add_sum[WIDTH-1] != op1[WIDTH-1]);
                        end
                        F_SUB: begin
                            fin_res   = sub_diff[WIDTH-1:0];
                            fin_carry = sub_diff[WIDTH];
                            fin_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                                        (sub_diff[WIDTH-1] != op1[WIDTH-1]);
                        end
                        F_SLT:  fin_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
                        F_SLTU: fin_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
                        F_SLL:  fin_res = op1 << shamt;
                        F_SRL:  fin_res = op1 >> shamt;
                        F_SRA:  fin_res = $signed(op1) >>> shamt;
                        F_MULU: begin
                            fin_valid = 1'b0;
                            load      = 1'b1;
                            state_nxt = S_MUL;
                        end
                        F_DIVU: begin
                            if (op2 == '0) begin
                                // Divide by zero finishes immediately.
                                fin_res = '1;
                                fin_hi  = op1;
                                fin_dz  = 1'b1;
                            end else begin
                                fin_valid = 1'b0;
                                load      = 1'b1;
                                state_nxt = S_DIV;
                            end
                        end
                        default: fin_err = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                if (last_iter) begin
                    fin_valid = 1'b1;
                    fin_res   = step_lo;
                    fin_hi    = step_hi;
                    fin_ovf   = (step_hi != '0);
                    state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                if (last_iter) begin
                    fin_valid = 1'b1;
                    fin_res   = step_lo;
                    fin_hi    = step_hi;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Latch operands on acceptance, then advance one iteration per cycle.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, because an aborted op must leave no internal state behind.
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= op1;
            opb_q <= op2;
            cnt_q <= '0;
        end else if (state != S_IDLE) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Registered done pulse; result and flags update only alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            sign      <= 1'b0;
            ovf       <= 1'b0;
            carry     <= 1'b0;
            dz        <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= fin_valid;
            if (fin_valid) begin
                result    <= fin_res;
                result_hi <= fin_hi;
                zero      <= fin_zero;
                sign      <= fin_sign;
                ovf       <= fin_ovf;
                carry     <= fin_carry;
                dz        <= fin_dz;
                err       <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int MASK = MOD - 1;

    typedef logic [2*W+5:0] outs_t;   // {result, result_hi, zero, sign, ovf, carry, dz, err}
    typedef logic [2*W+7:0] full_t;   // {busy, done, outs_t}

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic [CW-1:0] func;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          zero;
    logic          sign;
    logic          ovf;
    logic          carry;
    logic          dz;
    logic          err;

    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t exp_hold;

    alu_seq #(.WIDTH(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op1       (op1),
        .op2       (op2),
        .func      (func),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .sign      (sign),
        .ovf       (ovf),
        .carry     (carry),
        .dz        (dz),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic full_t observed();
        return {busy, done, result, result_hi, zero, sign, ovf, carry, dz, err};
    endfunction

    function automatic outs_t mk(input int r, input int hi, input bit z, input bit s,
                                 input bit o, input bit c, input bit d, input bit e);
        logic [31:0] rv;
        logic [31:0] hv;
        rv = r;
        hv = hi;
        return {rv[W-1:0], hv[W-1:0], z, s, o, c, d, e};
    endfunction

    // Reference model: expected outputs from plain integer arithmetic.
    function automatic outs_t model(input int f, input int a, input int b, output bit multi);
        int r, hi, sa, sb, amt;
        bit ov, cy, dzf, er;
        r = 0; hi = 0; ov = 0; cy = 0; dzf = 0; er = 0; multi = 0;
        sa  = (a >= HALF) ? a - MOD : a;
        sb  = (b >= HALF) ? b - MOD : b;
        amt = b % W;
        case (f)
            0: r = a & b;
            1: r = a | b;
            2: begin
                r  = (a + b) % MOD;
                cy = (a + b) >= MOD;
                ov = (sa + sb > HALF - 1) || (sa + sb < -HALF);
            end
            3: begin
                r  = (a - b + MOD) % MOD;
                cy = a < b;
                ov = (sa - sb > HALF - 1) || (sa - sb < -HALF);
            end
            4: r = a ^ b;
            5: r = ~(a | b) & MASK;
            6: r = (sa < sb) ? 1 : 0;
            7: r = (a < b) ? 1 : 0;
            8: r = (a << amt) % MOD;
            9: r = a >> amt;
            10: r = (sa >>> amt) & MASK;
            11: begin
                multi = 1;
                r  = (a * b) % MOD;
                hi = (a * b) / MOD;
                ov = hi != 0;
            end
            12: begin
                if (b == 0) begin
                    r = MASK; hi = a; dzf = 1;
                end else begin
                    multi = 1;
                    r = a / b; hi = a % b;
                end
            end
            default: er = 1;
        endcase
        return mk(r, hi, r == 0, r >= HALF, ov, cy, dzf, er);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge, then scramble the inputs.
    task automatic issue(input int f, input int a, input int b);
        logic [31:0] fv, av, bv;
        fv = f; av = a; bv = b;
        start = 1'b1;
        func  = fv[CW-1:0];
        op1   = av[W-1:0];
        op2   = bv[W-1:0];
        step();
        start = 1'b0;
        func  = CW'($urandom);
        op1   = W'($urandom);
        op2   = W'($urandom);
    endtask

    task automatic test_reset();
        full_t got;
        rst_n = 1'b0;
        start = 1'b1;
        func  = 4'd2;
        op1   = 8'h11;
        op2   = 8'h22;
        step();
        step();
        got = observed();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", got, full_t'(0));
        end
        rst_n    = 1'b1;
        start    = 1'b0;
        exp_hold = '0;
    endtask

    task automatic test_add_neg();
        full_t got, want;
        issue(2, 'hF8, 'h01);
        want = {1'b0, 1'b1, mk('hF9, 0, 0, 1, 0, 0, 0, 0)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL add_neg: got %h want %h", got, want);
        end
        exp_hold = want[2*W+5:0];
        step();
        want = {1'b0, 1'b0, exp_hold};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL add_neg_hold: got %h want %h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        full_t got, want;
        issue(2, 'h7F, 'h01);
        want = {1'b0, 1'b1, mk('h80, 0, 0, 1, 1, 0, 0, 0)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL b2b_add_ovf: got %h want %h", got, want);
        end
        issue(3, 'h05, 'h05);
        want = {1'b0, 1'b1, mk('h00, 0, 1, 0, 0, 0, 0, 0)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL b2b_sub_zero: got %h want %h", got, want);
        end
        exp_hold = want[2*W+5:0];
    endtask

    task automatic test_mul_ignore();
        full_t got, want;
        issue(11, 'hFF, 'hFF);
        for (int k = 1; k <= W; k++) begin
            want = {1'b1, 1'b0, exp_hold};
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL mul_busy_c%0d: got %h want %h", k, got, want);
            end
            if (k == 3) begin
                start = 1'b1; func = 4'd2; op1 = 8'h01; op2 = 8'h01;
            end else begin
                start = 1'b0;
            end
            step();
        end
        want = {1'b0, 1'b1, mk('h01, 'hFE, 0, 0, 1, 0, 0, 0)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL mul_done: got %h want %h", got, want);
        end
        exp_hold = want[2*W+5:0];
        step();
        want = {1'b0, 1'b0, exp_hold};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL mul_ignored_start: got %h want %h", got, want);
        end
    endtask

    task automatic test_div();
        full_t got, want;
        issue(12, 200, 7);
        for (int k = 1; k <= W; k++) begin
            want = {1'b1, 1'b0, exp_hold};
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL div_busy_c%0d: got %h want %h", k, got, want);
            end
            step();
        end
        want = {1'b0, 1'b1, mk('h1C, 'h04, 0, 0, 0, 0, 0, 0)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL div_done: got %h want %h", got, want);
        end
        issue(12, 13, 0);
        want = {1'b0, 1'b1, mk('hFF, 'h0D, 0, 1, 0, 0, 1, 0)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL div_by_zero: got %h want %h", got, want);
        end
        exp_hold = want[2*W+5:0];
    endtask

    task automatic test_reset_abort();
        full_t got, want;
        issue(11, 'h12, 'h34);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        got = observed();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL abort_reset: got %h want %h", got, full_t'(0));
        end
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            step();
            got = observed();
            n_cmp++;
            if (got !== '0) begin
                n_bad++;
                $display("FAIL abort_no_done_c%0d: got %h want %h", k, got, full_t'(0));
            end
        end
        issue(2, 2, 3);
        want = {1'b0, 1'b1, mk('h05, 0, 0, 0, 0, 0, 0, 0)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL abort_then_add: got %h want %h", got, want);
        end
        exp_hold = want[2*W+5:0];
    endtask

    task automatic test_illegal();
        full_t got, want;
        issue(14, 'h5A, 'hA5);
        want = {1'b0, 1'b1, mk(0, 0, 1, 0, 0, 0, 0, 1)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL illegal_func: got %h want %h", got, want);
        end
        issue(10, 'h80, 3);
        want = {1'b0, 1'b1, mk('hF0, 0, 0, 1, 0, 0, 0, 0)};
        got  = observed();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL sra_clears_err: got %h want %h", got, want);
        end
        exp_hold = want[2*W+5:0];
    endtask

    task automatic test_random(input int n_ops);
        full_t got, want;
        outs_t e;
        bit    multi;
        int    f, a, b;
        for (int i = 0; i < n_ops; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0;
                step();
                want = {1'b0, 1'b0, exp_hold};
                got  = observed();
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL rnd_idle_%0d: got %h want %h", i, got, want);
                end
            end
            f = $urandom_range(0, 15);
            a = $urandom_range(0, MASK);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
            e = model(f, a, b, multi);
            issue(f, a, b);
            if (multi) begin
                for (int k = 1; k <= W; k++) begin
                    want = {1'b1, 1'b0, exp_hold};
                    got  = observed();
                    n_cmp++;
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL rnd_busy_%0d_c%0d f=%0d: got %h want %h", i, k, f, got, want);
                    end
                    start = 1'($urandom);
                    func  = CW'($urandom);
                    step();
                end
                start = 1'b0;
            end
            want = {1'b0, 1'b1, e};
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL rnd_done_%0d f=%0d a=%0h b=%0h: got %h want %h", i, f, a, b, got, want);
            end
            exp_hold = e;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        func  = '0;
        op1   = '0;
        op2   = '0;
        test_reset();
        test_add_neg();
        test_back_to_back();
        test_mul_ignore();
        test_div();
        test_reset_abort();
        test_illegal();
        test_random(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
